// File: rtl/aipp_vrm_responder.sv
// VRM-side responder for the AIPP pre-trigger protocol: ramps VID idle->boost on a
// trigger, holds boost through the released load burst, ramps back, and reports lead time.
module aipp_vrm_responder #(
    parameter int VID_W      = 8,
    parameter int VID_IDLE   = 80,
    parameter int VID_BOOST  = 120,
    parameter int STEP       = 4,
    parameter int STEP_CYC   = 1000,
    parameter int HOLD_CYC   = 2000,
    parameter int ORPHAN_CYC = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vrm_trigger,
    input  logic             data_release,
    output logic [VID_W-1:0] vid_out,
    output logic             power_good,
    output logic             ramping,
    output logic [31:0]      lead_cycles,
    output logic             lead_valid,
    output logic             err_late,
    output logic             err_orphan,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_BOOSTED   = 3'd2,
        S_LOAD      = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_t;

    localparam logic [VID_W:0]   BOOST_X = (VID_W+1)'(VID_BOOST);
    localparam logic [VID_W:0]   IDLE_X  = (VID_W+1)'(VID_IDLE);
    localparam logic [VID_W:0]   STEP_X  = (VID_W+1)'(STEP);
    localparam logic [VID_W-1:0] BOOST_V = VID_W'(VID_BOOST);
    localparam logic [VID_W-1:0] IDLE_V  = VID_W'(VID_IDLE);

    state_t           state_q, state_d;
    logic [VID_W-1:0] vid_q, vid_d, vid_up, vid_dn;
    logic [VID_W:0]   vid_x, vid_up_x;
    // One timer serves as step, hold and orphan timer; the states never overlap.
    logic [31:0]      tmr_q, tmr_d;
    logic [31:0]      lead_cnt_q, lead_cnt_d, lead_inc;
    logic [31:0]      lead_cycles_d;
    logic             pend_q, pend_d;
    logic             lead_done_q, lead_done_d;
    logic             lead_valid_d, err_late_d, err_orphan_d;
    logic             step_wrap, report;

    assign vid_x     = {1'b0, vid_q};
    assign vid_up_x  = vid_x + STEP_X;
    assign vid_up    = (vid_up_x > BOOST_X) ? BOOST_V : vid_up_x[VID_W-1:0];
    assign vid_dn    = (vid_x < IDLE_X + STEP_X) ? IDLE_V : VID_W'(vid_x - STEP_X);
    assign step_wrap = (tmr_q == 32'(STEP_CYC - 1));
    assign lead_inc  = (lead_cnt_q == '1) ? lead_cnt_q : lead_cnt_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        vid_d         = vid_q;
        tmr_d         = tmr_q + 32'd1;
        pend_d        = pend_q;
        lead_cnt_d    = lead_inc;
        lead_done_d   = lead_done_q;
        lead_cycles_d = lead_cycles;
        lead_valid_d  = 1'b0;
        err_late_d    = 1'b0;
        err_orphan_d  = 1'b0;
        report        = 1'b0;
        unique case (state_q)
            S_IDLE, S_RAMP_DOWN: begin
                if (data_release || vrm_trigger) begin
                    state_d     = S_RAMP_UP;
                    tmr_d       = '0;
                    lead_cnt_d  = '0;
                    lead_done_d = 1'b0;
                    // A release here doubles as the trigger and reports zero lead.
                    if (data_release) begin
                        err_late_d    = 1'b1;
                        pend_d        = 1'b1;
                        lead_cycles_d = '0;
                        lead_valid_d  = 1'b1;
                        lead_done_d   = 1'b1;
                    end
                end else if (state_q == S_RAMP_DOWN && step_wrap) begin
                    tmr_d = '0;
                    vid_d = vid_dn;
                    if (vid_dn == IDLE_V) state_d = S_IDLE;
                end
            end
            S_RAMP_UP: begin
                if (data_release) begin
                    err_late_d = 1'b1;
                    pend_d     = 1'b1;
                    report     = 1'b1;
                end
                if (step_wrap) begin
                    tmr_d = '0;
                    vid_d = vid_up;
                    if (vid_up == BOOST_V) begin
                        if (pend_d) begin
                            state_d = S_LOAD;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_BOOSTED;
                        end
                    end
                end
            end
            S_BOOSTED: begin
                if (data_release) begin
                    state_d = S_LOAD;
                    tmr_d   = '0;
                    report  = 1'b1;
                end else if (vrm_trigger) begin
                    tmr_d = '0;
                end else if (tmr_q == 32'(ORPHAN_CYC - 1)) begin
                    err_orphan_d = 1'b1;
                    state_d      = S_RAMP_DOWN;
                    tmr_d        = '0;
                end
            end
            S_LOAD: begin
                if (data_release || vrm_trigger) begin
                    tmr_d  = '0;
                    report = data_release;
                end else if (tmr_q == 32'(HOLD_CYC - 1)) begin
                    state_d = S_RAMP_DOWN;
                    tmr_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Only the first release after acceptance updates the lead measurement.
        if (report && !lead_done_q) begin
            lead_cycles_d = lead_inc;
            lead_valid_d  = 1'b1;
            lead_done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vid_q       <= IDLE_V;
            tmr_q       <= '0;
            lead_cnt_q  <= '0;
            pend_q      <= 1'b0;
            lead_done_q <= 1'b0;
            lead_cycles <= '0;
            lead_valid  <= 1'b0;
            err_late    <= 1'b0;
            err_orphan  <= 1'b0;
            power_good  <= 1'b0;
            ramping     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vid_q       <= vid_d;
            tmr_q       <= tmr_d;
            lead_cnt_q  <= lead_cnt_d;
            pend_q      <= pend_d;
            lead_done_q <= lead_done_d;
            lead_cycles <= lead_cycles_d;
            lead_valid  <= lead_valid_d;
            err_late    <= err_late_d;
            err_orphan  <= err_orphan_d;
            power_good  <= (state_d == S_BOOSTED) || (state_d == S_LOAD);
            ramping     <= (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
        end
    end

    assign vid_out   = vid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aipp_vrm_responder.sv
// Bench for aipp_vrm_responder: scaled-timing scenario table, hand-written corner
// sequences, and randomized pulses checked against a deadline-based reference model.
module tb_aipp_vrm_responder;

    localparam int SC = 10;
    localparam int HC = 20;
    localparam int OC = 200;
    localparam int V_IDLE = 80;
    localparam int V_BOOST = 120;
    localparam int V_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        rel = 1'b0;
    logic [7:0]  vid, vid2;
    logic        pg, rmp, lv, late, orph;
    logic        pg2, rmp2, lv2, late2, orph2;
    logic [31:0] lead, lead2;
    logic [2:0]  st, st2;
    logic [44:0] obs, obs2;

    aipp_vrm_responder #(.VID_W(8), .VID_IDLE(V_IDLE), .VID_BOOST(V_BOOST), .STEP(V_STEP),
        .STEP_CYC(SC), .HOLD_CYC(HC), .ORPHAN_CYC(OC)) dut (
        .clk(clk), .rst_n(rst_n), .vrm_trigger(trig), .data_release(rel),
        .vid_out(vid), .power_good(pg), .ramping(rmp), .lead_cycles(lead),
        .lead_valid(lv), .err_late(late), .err_orphan(orph), .dbg_state(st));

    aipp_vrm_responder #(.VID_W(8), .VID_IDLE(V_IDLE), .VID_BOOST(122), .STEP(V_STEP),
        .STEP_CYC(SC), .HOLD_CYC(HC), .ORPHAN_CYC(OC)) dut2 (
        .clk(clk), .rst_n(rst_n), .vrm_trigger(trig), .data_release(rel),
        .vid_out(vid2), .power_good(pg2), .ramping(rmp2), .lead_cycles(lead2),
        .lead_valid(lv2), .err_late(late2), .err_orphan(orph2), .dbg_state(st2));

    assign obs  = {vid, pg, rmp, late, orph, lv, lead};
    assign obs2 = {vid2, pg2, rmp2, late2, orph2, lv2, lead2};

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_no = -1;
    logic [44:0] exp_q[$];

    typedef struct {
        int          sc;
        int          at;
        logic        t;
        logic        r;
        logic [7:0]  vid;
        logic        pg;
        logic        rmp;
        logic        late;
        logic        orph;
        logic        lv;
        logic [31:0] lead;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [44:0] act, input logic [44:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vid/pg/rmp/late/orph/lv/lead act=%0d/%b/%b/%b/%b/%b/%0d exp=%0d/%b/%b/%b/%b/%b/%0d",
                name, act[44:37], act[36], act[35], act[34], act[33], act[32], act[31:0],
                exp[44:37], exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // driver tasks
    task automatic tick(input logic t, input logic r);
        trig = t;
        rel  = r;
        @(posedge clk);
        #1;
        trig = 1'b0;
        rel  = 1'b0;
        edge_no++;
    endtask

    task automatic go_to(input int at, input logic t, input logic r);
        while (edge_no < at - 1) tick(1'b0, 1'b0);
        tick(t, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edge_no = -1;
    endtask

    task automatic add(input int sc, input int at, input logic t, input logic r, input int v,
                       input logic p, input logic rm, input logic la, input logic o,
                       input logic l, input int ld);
        vec_t x;
        x.sc = sc; x.at = at; x.t = t; x.r = r; x.vid = 8'(v); x.pg = p; x.rmp = rm;
        x.late = la; x.orph = o; x.lv = l; x.lead = 32'(ld);
        vt.push_back(x);
    endtask

    // reference model: absolute deadlines instead of counters
    localparam int M_IDLE = 0, M_UP = 1, M_BOOST = 2, M_LOAD = 3, M_DOWN = 4;
    int   m_mode, m_vid, m_step_due, m_hold_end, m_orph_end, m_acc, m_lead;
    logic m_pend, m_done, m_lv, m_late, m_orph;

    task automatic model_reset();
        m_mode = M_IDLE; m_vid = V_IDLE; m_pend = 0; m_done = 0; m_lead = 0;
        m_lv = 0; m_late = 0; m_orph = 0; m_step_due = 0; m_hold_end = 0; m_orph_end = 0;
        m_acc = 0;
    endtask

    task automatic model_report(input int e);
        if (!m_done) begin
            m_lead = e - m_acc;
            m_lv = 1;
            m_done = 1;
        end
    endtask

    task automatic model_step(input int e, input logic t, input logic r);
        m_lv = 0; m_late = 0; m_orph = 0;
        case (m_mode)
            M_IDLE, M_DOWN: begin
                if (r || t) begin
                    m_mode = M_UP; m_acc = e; m_step_due = e + SC; m_done = 0;
                    if (r) begin
                        m_late = 1; m_pend = 1; m_lead = 0; m_lv = 1; m_done = 1;
                    end
                end else if (m_mode == M_DOWN && e == m_step_due) begin
                    m_vid = (m_vid - V_STEP < V_IDLE) ? V_IDLE : m_vid - V_STEP;
                    m_step_due = e + SC;
                    if (m_vid == V_IDLE) m_mode = M_IDLE;
                end
            end
            M_UP: begin
                if (r) begin
                    m_late = 1; m_pend = 1;
                    model_report(e);
                end
                if (e == m_step_due) begin
                    m_vid = (m_vid + V_STEP > V_BOOST) ? V_BOOST : m_vid + V_STEP;
                    m_step_due = e + SC;
                    if (m_vid == V_BOOST) begin
                        if (m_pend) begin
                            m_mode = M_LOAD; m_pend = 0; m_hold_end = e + HC;
                        end else begin
                            m_mode = M_BOOST; m_orph_end = e + OC;
                        end
                    end
                end
            end
            M_BOOST: begin
                if (r) begin
                    m_mode = M_LOAD; m_hold_end = e + HC;
                    model_report(e);
                end else if (t) begin
                    m_orph_end = e + OC;
                end else if (e == m_orph_end) begin
                    m_orph = 1; m_mode = M_DOWN; m_step_due = e + SC;
                end
            end
            default: begin
                if (r || t) begin
                    m_hold_end = e + HC;
                    if (r) model_report(e);
                end else if (e == m_hold_end) begin
                    m_mode = M_DOWN; m_step_due = e + SC;
                end
            end
        endcase
    endtask

    function automatic logic [44:0] model_pack();
        return {8'(m_vid), (m_mode == M_BOOST || m_mode == M_LOAD),
                (m_mode == M_UP || m_mode == M_DOWN), m_late, m_orph, m_lv, 32'(m_lead)};
    endfunction

    initial begin
        int prev_sc;
        logic t, r;
        logic [44:0] e_vec;

        // scenario table (timing scaled: STEP_CYC=10, HOLD_CYC=20, ORPHAN_CYC=200)
        //  sc  at  t r  vid pg rm la or lv lead
        add(1,   0, 1,0,  80, 0, 1, 0, 0, 0,   0);
        add(1,   9, 0,0,  80, 0, 1, 0, 0, 0,   0);
        add(1,  10, 0,0,  84, 0, 1, 0, 0, 0,   0);
        add(1,  99, 0,0, 116, 0, 1, 0, 0, 0,   0);
        add(1, 100, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(1, 140, 0,1, 120, 1, 0, 0, 0, 1, 140);
        add(1, 141, 0,0, 120, 1, 0, 0, 0, 0, 140);
        add(1, 159, 0,0, 120, 1, 0, 0, 0, 0, 140);
        add(1, 160, 0,0, 120, 0, 1, 0, 0, 0, 140);
        add(1, 170, 0,0, 116, 0, 1, 0, 0, 0, 140);
        add(1, 259, 0,0,  84, 0, 1, 0, 0, 0, 140);
        add(1, 260, 0,0,  80, 0, 0, 0, 0, 0, 140);
        add(2,   0, 1,0,  80, 0, 1, 0, 0, 0,   0);
        add(2,  50, 0,1, 100, 0, 1, 1, 0, 1,  50);
        add(2,  51, 0,0, 100, 0, 1, 0, 0, 0,  50);
        add(2, 100, 0,0, 120, 1, 0, 0, 0, 0,  50);
        add(2, 110, 0,1, 120, 1, 0, 0, 0, 0,  50);
        add(2, 129, 0,0, 120, 1, 0, 0, 0, 0,  50);
        add(2, 130, 0,0, 120, 0, 1, 0, 0, 0,  50);
        add(3,   0, 1,0,  80, 0, 1, 0, 0, 0,   0);
        add(3, 100, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(3, 299, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(3, 300, 0,0, 120, 0, 1, 0, 1, 0,   0);
        add(3, 301, 0,0, 120, 0, 1, 0, 0, 0,   0);
        add(3, 310, 0,0, 116, 0, 1, 0, 0, 0,   0);
        add(3, 400, 0,0,  80, 0, 0, 0, 0, 0,   0);
        add(4,   0, 1,0,  80, 0, 1, 0, 0, 0,   0);
        add(4, 140, 0,1, 120, 1, 0, 0, 0, 1, 140);
        add(4, 190, 0,0, 108, 0, 1, 0, 0, 0, 140);
        add(4, 195, 1,0, 108, 0, 1, 0, 0, 0, 140);
        add(4, 204, 0,0, 108, 0, 1, 0, 0, 0, 140);
        add(4, 205, 0,0, 112, 0, 1, 0, 0, 0, 140);
        add(4, 225, 0,0, 120, 1, 0, 0, 0, 0, 140);
        add(4, 230, 0,1, 120, 1, 0, 0, 0, 1,  35);
        add(4, 231, 0,0, 120, 1, 0, 0, 0, 0,  35);
        add(5,   0, 0,1,  80, 0, 1, 1, 0, 1,   0);
        add(5,   1, 0,0,  80, 0, 1, 0, 0, 0,   0);
        add(5, 100, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(5, 119, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(5, 120, 0,0, 120, 0, 1, 0, 0, 0,   0);
        add(6,   0, 1,1,  80, 0, 1, 1, 0, 1,   0);
        add(6, 100, 0,0, 120, 1, 0, 0, 0, 0,   0);
        add(6, 120, 0,0, 120, 0, 1, 0, 0, 0,   0);

        // reset state
        @(posedge clk);
        #1;
        chk("reset_state", obs, {8'd80, 37'd0});

        prev_sc = -1;
        foreach (vt[i]) begin
            if (vt[i].sc != prev_sc) do_reset();
            prev_sc = vt[i].sc;
            go_to(vt[i].at, vt[i].t, vt[i].r);
            chk($sformatf("sc%0d@%0d", vt[i].sc, vt[i].at), obs,
                {vt[i].vid, vt[i].pg, vt[i].rmp, vt[i].late, vt[i].orph, vt[i].lv, vt[i].lead});
        end

        // asynchronous reset mid-ramp, then the next trigger replays normal timing
        do_reset();
        go_to(0, 1'b1, 1'b0);
        go_to(45, 1'b0, 1'b0);
        chk("pre_reset_vid", obs, {8'd96, 1'b0, 1'b1, 35'd0});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", obs, {8'd80, 37'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edge_no = -1;
        go_to(0, 1'b1, 1'b0);
        go_to(10, 1'b0, 1'b0);
        chk("replay@10", obs, {8'd84, 1'b0, 1'b1, 35'd0});
        go_to(100, 1'b0, 1'b0);
        chk("replay@100", obs, {8'd120, 1'b1, 1'b0, 35'd0});

        // boost code not on a step boundary saturates at 122 after 11 steps
        do_reset();
        go_to(0, 1'b1, 1'b0);
        go_to(100, 1'b0, 1'b0);
        chk("b122@100", obs2, {8'd120, 1'b0, 1'b1, 35'd0});
        go_to(109, 1'b0, 1'b0);
        chk("b122@109", obs2, {8'd120, 1'b0, 1'b1, 35'd0});
        go_to(110, 1'b0, 1'b0);
        chk("b122@110", obs2, {8'd122, 1'b1, 1'b0, 35'd0});

        // randomized pulses against the reference model
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            model_reset();
            exp_q.delete();
            for (int e = 0; e < 4000; e++) begin
                t = ($urandom_range(0, (ph == 0) ? 39 : 249) == 0);
                r = ($urandom_range(0, (ph == 0) ? 39 : 249) == 0);
                model_step(e, t, r);
                exp_q.push_back(model_pack());
                tick(t, r);
                e_vec = exp_q.pop_front();
                chk($sformatf("rand%0d@%0d", ph, e), obs, e_vec);
            end
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
